// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared definitions for the sequential execute-stage ALU:
//               opcode encoding (shared with the decoder), flag register bit
//               indices and the control state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPC_W = 5;

    // Opcode encoding; any value not listed completes as a no-op.
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OP_INC  = 5'd2;
    localparam logic [OPC_W-1:0] OP_CMP  = 5'd3;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd4;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd5;
    localparam logic [OPC_W-1:0] OP_XOR  = 5'd6;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd7;
    localparam logic [OPC_W-1:0] OP_RR   = 5'd8;
    localparam logic [OPC_W-1:0] OP_RL   = 5'd9;
    localparam logic [OPC_W-1:0] OP_SETB = 5'd10;
    localparam logic [OPC_W-1:0] OP_CLRB = 5'd11;
    localparam logic [OPC_W-1:0] OP_CPLB = 5'd12;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd13;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd14;
    localparam logic [OPC_W-1:0] OP_SETF = 5'd15;
    localparam logic [OPC_W-1:0] OP_CLRF = 5'd16;
    localparam logic [OPC_W-1:0] OP_CPLF = 5'd17;
    localparam logic [OPC_W-1:0] OP_MOVB = 5'd18;
    localparam logic [OPC_W-1:0] OP_LBH  = 5'd19;
    localparam logic [OPC_W-1:0] OP_LBL  = 5'd20;
    localparam logic [OPC_W-1:0] OP_MOV  = 5'd21;

    // Flag register bit positions.
    localparam int FLG_C   = 0;
    localparam int FLG_V   = 1;
    localparam int FLG_CMP = 2;
    localparam int FLG_EQ  = 3;
    localparam int FLG_IO  = 4;
    localparam int FLG_P   = 5;
    localparam int FLG_N   = 6;
    localparam int FLG_Z   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Interface   : seq_alu_if
// Description : Operation/result handshake bundle of the sequential ALU.
//               master = decode/operand-fetch + writeback side,
//               slave  = the ALU.
//   in_valid/in_ready   : operation handshake (opcode, op_a, op_b, imm,
//                         bit_pos, bit_in)
//   out_valid/out_ready : result handshake (result_lo, result_hi, wr_hi)
//   flags               : committed flag register
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FLAG_W = 8
);
    localparam int BP_W = $clog2(WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [OPC_W-1:0]      opcode;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH/2-1:0]    imm;
    logic [BP_W-1:0]       bit_pos;
    logic                  bit_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      result_lo;
    logic [WIDTH-1:0]      result_hi;
    logic                  wr_hi;
    logic [FLAG_W-1:0]     flags;

    modport master (
        output in_valid, opcode, op_a, op_b, imm, bit_pos, bit_in, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, wr_hi, flags
    );

    modport slave (
        input  in_valid, opcode, op_a, op_b, imm, bit_pos, bit_in, out_ready,
        output in_ready, out_valid, result_lo, result_hi, wr_hi, flags
    );

endinterface
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv
// Description : Iterative unsigned multiplier / restoring divider sharing one
//               hi/lo shift register pair, a latched second operand and an
//               iteration counter. One step per cycle, WIDTH steps total.
//   clk, reset : clock, synchronous active-high reset (aborts the operation)
//   start      : load a/b and begin (is_div selects divide)
//   done       : high during the final step
//   hi, lo     : register contents after the current step; valid with done
//                (MUL: product hi/lo, DIV: remainder/quotient)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             is_div,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  done,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             busy_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   trial_w;

    always_comb begin
        // MUL: add multiplicand when the multiplier LSB is set, then shift
        // the (WIDTH+1)-bit sum and multiplier right together.
        add_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // DIV: shift remainder:quotient left and trial-subtract. Because the
        // remainder is always below the divisor, bit WIDTH is a clean borrow.
        trial_w = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
        if (is_div_q) begin
            if (!trial_w[WIDTH]) begin
                hi_d = trial_w[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = add_w[WIDTH:1];
            lo_d = {add_w[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= a;
            b_q      <= b;
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Results are taken from the step outputs so the final step's value is
    // captured on the same edge that completes it.
    assign done = busy_q && (cnt_q == CNT_LAST);
    assign hi   = hi_d;
    assign lo   = lo_d;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked execute-stage ALU with flag register. Single-cycle
//               arithmetic/logic/bit/flag/data ops; iterative MUL and DIV via
//               seq_muldiv. One operation in flight at a time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_alu_if slave (operation in, result + flags out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FLAG_W = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    seq_alu_if.slave   bus
);
    localparam int HALF = WIDTH / 2;

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              wr_hi_q;
    logic [WIDTH-1:0]  res_lo_q, res_hi_q;
    logic [FLAG_W-1:0] flags_q;

    logic              accept;
    logic              is_mul, is_div_nz;
    logic [WIDTH-1:0]  sc_lo_d, sc_hi_d;
    logic              sc_wr_hi_d;
    logic [FLAG_W-1:0] sc_flags_d;
    logic              upd_znp;
    logic [WIDTH:0]    sum_w;
    logic [WIDTH-1:0]  bit_mask;
    logic [FLAG_W-1:0] flag_mask;
    logic              md_done;
    logic [WIDTH-1:0]  md_hi, md_lo;
    logic [FLAG_W-1:0] md_flags_d;

    assign accept    = bus.in_valid && in_ready_q;
    assign is_mul    = (bus.opcode == OP_MUL);
    assign is_div_nz = (bus.opcode == OP_DIV) && (bus.op_b != '0);
    assign bit_mask  = WIDTH'(1) << bus.bit_pos;
    // Flag indices past the register width select nothing.
    assign flag_mask = (int'(bus.bit_pos) < FLAG_W) ? (FLAG_W'(1) << bus.bit_pos) : '0;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the acceptance cycle.
    // ------------------------------------------------------------------
    always_comb begin
        sc_lo_d    = '0;
        sc_hi_d    = '0;
        sc_wr_hi_d = 1'b0;
        sc_flags_d = flags_q;
        upd_znp    = 1'b0;
        sum_w      = '0;
        case (bus.opcode)
            OP_ADD: begin
                sum_w             = {1'b0, bus.op_a} + {1'b0, bus.op_b};
                sc_lo_d           = sum_w[WIDTH-1:0];
                sc_flags_d[FLG_C] = sum_w[WIDTH];
                sc_flags_d[FLG_V] = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                                    (sum_w[WIDTH-1] != bus.op_a[WIDTH-1]);
                upd_znp           = 1'b1;
            end
            OP_INC: begin
                sum_w             = {1'b0, bus.op_a} + (WIDTH+1)'(1);
                sc_lo_d           = sum_w[WIDTH-1:0];
                sc_flags_d[FLG_C] = sum_w[WIDTH];
                sc_flags_d[FLG_V] = !bus.op_a[WIDTH-1] && sum_w[WIDTH-1];
                upd_znp           = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // Bit WIDTH of the extended difference is the borrow (a < b).
                sum_w              = {1'b0, bus.op_a} - {1'b0, bus.op_b};
                sc_flags_d[FLG_C]  = sum_w[WIDTH];
                sc_flags_d[FLG_V]  = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                                     (sum_w[WIDTH-1] != bus.op_a[WIDTH-1]);
                sc_flags_d[FLG_EQ] = (bus.op_a == bus.op_b);
                if (bus.opcode == OP_CMP) begin
                    sc_flags_d[FLG_CMP] = (bus.op_a > bus.op_b);
                end else begin
                    sc_lo_d = sum_w[WIDTH-1:0];
                end
                upd_znp = 1'b1;
            end
            OP_AND:  begin sc_lo_d = bus.op_a & bus.op_b;                    upd_znp = 1'b1; end
            OP_OR:   begin sc_lo_d = bus.op_a | bus.op_b;                    upd_znp = 1'b1; end
            OP_XOR:  begin sc_lo_d = bus.op_a ^ bus.op_b;                    upd_znp = 1'b1; end
            OP_NOT:  begin sc_lo_d = ~bus.op_a;                              upd_znp = 1'b1; end
            OP_RR:   begin sc_lo_d = {bus.op_a[0], bus.op_a[WIDTH-1:1]};     upd_znp = 1'b1; end
            OP_RL:   begin sc_lo_d = {bus.op_a[WIDTH-2:0], bus.op_a[WIDTH-1]}; upd_znp = 1'b1; end
            OP_SETB: begin sc_lo_d = bus.op_a | bit_mask;                    upd_znp = 1'b1; end
            OP_CLRB: begin sc_lo_d = bus.op_a & ~bit_mask;                   upd_znp = 1'b1; end
            OP_CPLB: begin sc_lo_d = bus.op_a ^ bit_mask;                    upd_znp = 1'b1; end
            OP_DIV: begin
                // Only the divide-by-zero case completes here.
                sc_lo_d           = '1;
                sc_hi_d           = bus.op_a;
                sc_wr_hi_d        = 1'b1;
                sc_flags_d[FLG_V] = 1'b1;
            end
            OP_SETF: sc_flags_d = flags_q | flag_mask;
            OP_CLRF: sc_flags_d = flags_q & ~flag_mask;
            OP_CPLF: sc_flags_d = flags_q ^ flag_mask;
            OP_MOVB: sc_flags_d = bus.bit_in ? (flags_q | flag_mask) : (flags_q & ~flag_mask);
            OP_LBH:  sc_lo_d = {bus.imm, bus.op_a[HALF-1:0]};
            OP_LBL:  sc_lo_d = {bus.op_a[WIDTH-1:HALF], bus.imm};
            OP_MOV:  sc_lo_d = bus.op_a;
            default: ;
        endcase
        if (upd_znp) begin
            sc_flags_d[FLG_Z] = (sc_lo_d == '0);
            sc_flags_d[FLG_N] = sc_lo_d[WIDTH-1];
            sc_flags_d[FLG_P] = ~^sc_lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Iterative MUL / DIV
    // ------------------------------------------------------------------
    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && (is_mul || is_div_nz)),
        .is_div (is_div_nz),
        .a      (bus.op_a),
        .b      (bus.op_b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        md_flags_d = flags_q;
        if (state_q == ST_MUL) begin
            md_flags_d[FLG_C] = 1'b0;
            md_flags_d[FLG_V] = 1'b0;
            md_flags_d[FLG_Z] = ({md_hi, md_lo} == '0);
            md_flags_d[FLG_N] = md_hi[WIDTH-1];
        end else begin
            md_flags_d[FLG_Z] = (md_lo == '0);
            md_flags_d[FLG_N] = md_lo[WIDTH-1];
        end
        md_flags_d[FLG_P] = ~^md_lo;
    end

    // ------------------------------------------------------------------
    // Control FSM; results and flags commit on the edge out_valid rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wr_hi_q     <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_mul) begin
                            state_q <= ST_MUL;
                        end else if (is_div_nz) begin
                            state_q <= ST_DIV;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            res_lo_q    <= sc_lo_d;
                            res_hi_q    <= sc_hi_d;
                            wr_hi_q     <= sc_wr_hi_d;
                            flags_q     <= sc_flags_d;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        res_lo_q    <= md_lo;
                        res_hi_q    <= md_hi;
                        wr_hi_q     <= 1'b1;
                        flags_q     <= md_flags_d;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.wr_hi     = wr_hi_q;
    assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=16, FLAG_W=8).
//               Directed operations; expected results come from a behavioural
//               model using plain integer arithmetic, checked every cycle
//               out_valid is high, plus literal expectations for key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk;
    logic reset;

    seq_alu_if #(.WIDTH(W), .FLAG_W(8)) bus_if ();

    seq_alu #(.WIDTH(W), .FLAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_lo, exp_hi;
    logic        exp_wr;
    logic [7:0]  exp_flags;
    int          exp_lat;
    logic [7:0]  m_flags;
    logic [15:0] cap_lo, cap_hi;
    logic [7:0]  cap_flags;
    logic        cap_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: what the outputs must be, from the operation rules.
    task automatic model(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] imm, input int bp, input logic bi);
        int          sa, sb, s;
        logic [31:0] p;
        logic [15:0] lo, hi, msk;
        logic [7:0]  f;
        bit          znp;
        f = m_flags; lo = '0; hi = '0; znp = 0;
        exp_wr = 1'b0; exp_lat = 1;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        msk = 16'(1 << bp);
        case (opc)
            OP_ADD: begin
                lo = a + b; f[FLG_C] = (int'(a) + int'(b)) > 65535;
                s = sa + sb; f[FLG_V] = (s > 32767) || (s < -32768); znp = 1;
            end
            OP_INC: begin
                lo = a + 16'd1; f[FLG_C] = (int'(a) + 1) > 65535;
                s = sa + 1; f[FLG_V] = s > 32767; znp = 1;
            end
            OP_SUB, OP_CMP: begin
                f[FLG_C] = a < b; s = sa - sb; f[FLG_V] = (s > 32767) || (s < -32768);
                f[FLG_EQ] = a == b;
                if (opc == OP_CMP) f[FLG_CMP] = a > b;
                else lo = a - b;
                znp = 1;
            end
            OP_AND:  begin lo = a & b; znp = 1; end
            OP_OR:   begin lo = a | b; znp = 1; end
            OP_XOR:  begin lo = a ^ b; znp = 1; end
            OP_NOT:  begin lo = ~a; znp = 1; end
            OP_RR:   begin lo = (a >> 1) | (a << 15); znp = 1; end
            OP_RL:   begin lo = (a << 1) | (a >> 15); znp = 1; end
            OP_SETB: begin lo = a | msk; znp = 1; end
            OP_CLRB: begin lo = a & ~msk; znp = 1; end
            OP_CPLB: begin lo = a ^ msk; znp = 1; end
            OP_MUL: begin
                p = 32'(a) * 32'(b); lo = p[15:0]; hi = p[31:16];
                f[FLG_C] = 0; f[FLG_V] = 0; f[FLG_Z] = p == 0; f[FLG_N] = hi[15];
                f[FLG_P] = ($countones(lo) % 2) == 0;
                exp_wr = 1'b1; exp_lat = W + 1;
            end
            OP_DIV: begin
                exp_wr = 1'b1;
                if (b == 0) begin
                    lo = 16'hFFFF; hi = a; f[FLG_V] = 1;
                end else begin
                    lo = a / b; hi = a % b; znp = 1; exp_lat = W + 1;
                end
            end
            OP_SETF: if (bp < 8) f[bp] = 1'b1;
            OP_CLRF: if (bp < 8) f[bp] = 1'b0;
            OP_CPLF: if (bp < 8) f[bp] = ~f[bp];
            OP_MOVB: if (bp < 8) f[bp] = bi;
            OP_LBH:  lo = {imm, a[7:0]};
            OP_LBL:  lo = {a[15:8], imm};
            OP_MOV:  lo = a;
            default: ;
        endcase
        if (znp) begin
            f[FLG_Z] = lo == 0; f[FLG_N] = lo[15]; f[FLG_P] = ($countones(lo) % 2) == 0;
        end
        exp_lo = lo; exp_hi = hi; exp_flags = f; m_flags = f;
    endtask

    // Result checker: every cycle a result is presented (including stalls).
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid) begin
            chk("result_lo", 32'(bus_if.result_lo), 32'(exp_lo));
            chk("result_hi", 32'(bus_if.result_hi), 32'(exp_hi));
            chk("wr_hi",     32'(bus_if.wr_hi),     32'(exp_wr));
            chk("flags",     32'(bus_if.flags),     32'(exp_flags));
        end
    end

    task automatic issue(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] imm, input int bp, input logic bi);
        int guard;
        model(opc, a, b, imm, bp, bi);
        @(negedge clk);
        bus_if.opcode  = opc;
        bus_if.op_a    = a;
        bus_if.op_b    = b;
        bus_if.imm     = imm;
        bus_if.bit_pos = 4'(bp);
        bus_if.bit_in  = bi;
        guard = 0;
        while (!bus_if.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready before issue", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic finish(input int hold);
        int lat;
        bit busy_ok;
        bit held;
        lat = 1; busy_ok = 1; held = 1;
        while (!bus_if.out_valid && lat < 64) begin
            if (bus_if.in_ready) busy_ok = 0;
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        cap_lo = bus_if.result_lo; cap_hi = bus_if.result_hi;
        cap_wr = bus_if.wr_hi;     cap_flags = bus_if.flags;
        repeat (hold) begin
            if (bus_if.in_ready) busy_ok = 0;
            // Offer another operation while stalled; it must not be taken.
            bus_if.in_valid = 1'b1;
            @(posedge clk);
            #1 bus_if.in_valid = 1'b0;
            if (!bus_if.out_valid) held = 0;
        end
        if (bus_if.in_ready) busy_ok = 0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.out_ready = 1'b0;
        chk("in_ready low until handshake", 32'(busy_ok), 32'd1);
        chk("out_valid held under stall", 32'(held), 32'd1);
        chk("in_ready after handshake", 32'(bus_if.in_ready), 32'd1);
        chk("out_valid after handshake", 32'(bus_if.out_valid), 32'd0);
    endtask

    task automatic do_op(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] imm, input int bp, input logic bi, input int hold);
        issue(opc, a, b, imm, bp, bi);
        finish(hold);
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.opcode    = '0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.imm       = '0;
        bus_if.bit_pos   = '0;
        bus_if.bit_in    = 1'b0;
        m_flags          = '0;
        exp_lo = '0; exp_hi = '0; exp_wr = 1'b0; exp_flags = '0; exp_lat = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("reset out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("reset wr_hi",     32'(bus_if.wr_hi),     32'd0);
        chk("reset result_lo", 32'(bus_if.result_lo), 32'd0);
        chk("reset result_hi", 32'(bus_if.result_hi), 32'd0);
        chk("reset flags",     32'(bus_if.flags),     32'd0);
        @(negedge clk) reset = 1'b0;

        // ADD overflow: V=1, N=1, C=Z=P=0
        do_op(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 0, 1'b0, 0);
        chk("ADD lo literal",    32'(cap_lo),    32'h8000);
        chk("ADD flags literal", 32'(cap_flags), 32'h42);

        // MUL 0x1234 * 0x0100
        do_op(OP_MUL, 16'h1234, 16'h0100, 8'h00, 0, 1'b0, 0);
        chk("MUL hi literal", 32'(cap_hi), 32'h0012);
        chk("MUL lo literal", 32'(cap_lo), 32'h3400);
        chk("MUL wr literal", 32'(cap_wr), 32'd1);

        // DIV 100 / 7 and divide by zero
        do_op(OP_DIV, 16'd100, 16'd7, 8'h00, 0, 1'b0, 0);
        chk("DIV q literal", 32'(cap_lo), 32'd14);
        chk("DIV r literal", 32'(cap_hi), 32'd2);
        do_op(OP_DIV, 16'd5, 16'd0, 8'h00, 0, 1'b0, 0);
        chk("DIV0 lo literal", 32'(cap_lo), 32'hFFFF);
        chk("DIV0 hi literal", 32'(cap_hi), 32'd5);
        chk("DIV0 V literal",  32'(cap_flags[FLG_V]), 32'd1);

        // CMP equal, then flag ops
        do_op(OP_CMP,  16'd3, 16'd3, 8'h00, 0, 1'b0, 0);
        chk("CMP flags literal", 32'(cap_flags), 32'hA8);
        do_op(OP_CPLF, 16'd0, 16'd0, 8'h00, 3, 1'b0, 0);
        chk("CPLF flags literal", 32'(cap_flags), 32'hA0);
        do_op(OP_SETF, 16'd0, 16'd0, 8'h00, 12, 1'b0, 0);
        chk("SETF12 flags literal", 32'(cap_flags), 32'hA0);

        // SUB with backpressure
        do_op(OP_SUB, 16'd2, 16'd5, 8'h00, 0, 1'b0, 5);
        chk("SUB lo literal", 32'(cap_lo), 32'hFFFD);
        chk("SUB C literal",  32'(cap_flags[FLG_C]), 32'd1);

        // Remaining operations, model-checked
        do_op(OP_INC,  16'hFFFF, 16'h0000, 8'h00, 0,  1'b0, 0);
        do_op(OP_INC,  16'h7FFF, 16'h0000, 8'h00, 0,  1'b0, 1);
        do_op(OP_ADD,  16'hFFFF, 16'h0002, 8'h00, 0,  1'b0, 0);
        do_op(OP_SUB,  16'h8000, 16'h0001, 8'h00, 0,  1'b0, 0);
        do_op(OP_CMP,  16'h0009, 16'h0004, 8'h00, 0,  1'b0, 0);
        do_op(OP_AND,  16'hF0F0, 16'h3C3C, 8'h00, 0,  1'b0, 0);
        do_op(OP_OR,   16'hF000, 16'h000F, 8'h00, 0,  1'b0, 0);
        do_op(OP_XOR,  16'hAAAA, 16'hAAAA, 8'h00, 0,  1'b0, 0);
        do_op(OP_NOT,  16'h00FF, 16'h0000, 8'h00, 0,  1'b0, 0);
        do_op(OP_RR,   16'h0001, 16'h0000, 8'h00, 0,  1'b0, 0);
        do_op(OP_RL,   16'h8001, 16'h0000, 8'h00, 0,  1'b0, 0);
        do_op(OP_SETB, 16'h0000, 16'h0000, 8'h00, 15, 1'b0, 0);
        do_op(OP_CLRB, 16'hFFFF, 16'h0000, 8'h00, 4,  1'b0, 0);
        do_op(OP_CPLB, 16'h1234, 16'h0000, 8'h00, 2,  1'b0, 2);
        do_op(OP_MOVB, 16'h0000, 16'h0000, 8'h00, 4,  1'b1, 0);
        do_op(OP_CLRF, 16'h0000, 16'h0000, 8'h00, 6,  1'b0, 0);
        do_op(OP_LBH,  16'hABCD, 16'h0000, 8'h5A, 0,  1'b0, 0);
        chk("LBH lo literal", 32'(cap_lo), 32'h5ACD);
        do_op(OP_LBL,  16'hABCD, 16'h0000, 8'h5A, 0,  1'b0, 0);
        chk("LBL lo literal", 32'(cap_lo), 32'hAB5A);
        do_op(OP_MOV,  16'h8421, 16'h0000, 8'h00, 0,  1'b0, 0);
        do_op(5'd31,   16'h1111, 16'h2222, 8'h00, 0,  1'b0, 0);
        do_op(OP_MUL,  16'hFFFF, 16'hFFFF, 8'h00, 0,  1'b0, 3);
        do_op(OP_MUL,  16'h0000, 16'h1234, 8'h00, 0,  1'b0, 0);
        do_op(OP_DIV,  16'hFFFF, 16'h0001, 8'h00, 0,  1'b0, 0);
        do_op(OP_DIV,  16'h0003, 16'h8000, 8'h00, 0,  1'b0, 2);

        // Reset in the middle of a MUL
        issue(OP_MUL, 16'h00FF, 16'h0101, 8'h00, 0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("in_ready during MUL", 32'(bus_if.in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_flags = '0;
        chk("mid-op reset out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid-op reset in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("mid-op reset flags",     32'(bus_if.flags),     32'd0);
        do_op(OP_MUL, 16'd3, 16'd4, 8'h00, 0, 1'b0, 0);
        chk("MUL after reset lo", 32'(cap_lo), 32'd12);
        chk("MUL after reset hi", 32'(cap_hi), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
